// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style multi-cycle control FSM for an RV32I datapath. Sequences
// FETCH / DECODE / EXEC / MEM / WB. Each datapath control signal is driven
// only in the phase that uses it. Instruction and data memory are accessed
// through variable-latency req/ack handshakes.
//
// Handshake semantics (imem and dmem alike): the controller raises req and
// holds it, never retracting it, until the cycle in which ack is high. That
// cycle completes the transfer. An ack seen while req is low is ignored.
// A req that stays un-acked through the cycle in which wait_cnt == WAIT_MAX
// sends the FSM to TRAP with bus_err set. An ack in that same cycle still
// completes the transfer normally.
//
// Parameters
//   WAIT_CNT_W   width of the memory wait counter
//   WAIT_MAX     last un-acked cycle count tolerated (< 2**WAIT_CNT_W)
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   opcode         instr[6:0], sampled when ir_load is high
//   imem_ack       instruction memory ack
//   dmem_ack       data memory ack
//   imem_req       instruction fetch request
//   ir_load        instruction register load strobe
//   dmem_req       data memory request
//   dmem_we        data memory write enable (SW), valid with dmem_req
//   alu_src        0 = rs2, 1 = immediate
//   alu_op         00 add, 01 branch, 10 R-type, 11 I-type ALU
//   mem_to_reg     writeback from data memory
//   reg_write      register file write enable
//   branch         branch compare phase
//   jump           JAL/JALR target select
//   jalr           JALR target = rs1 + imm
//   pc_to_reg      writeback from PC path
//   pc_reg_src     01 AUIPC, 10 LUI, 00 JAL/JALR
//   pc_write       PC update, one cycle per retired instruction
//   illegal        sticky illegal-opcode trap flag
//   bus_err        sticky memory-timeout trap flag
//   retire_cnt     retired instruction count (0 unless CTRL_RETIRE_CNT_EN)
//   fsm_state      current FSM state encoding (debug observation)
//
// Build option
//   CTRL_RETIRE_CNT_EN  when defined, retire_cnt counts pc_write strobes and
//                       wraps at 2**32. When undefined, no counter is built
//                       and retire_cnt is tied to zero.
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int WAIT_CNT_W = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        branch,
  output logic        jump,
  output logic        jalr,
  output logic        pc_to_reg,
  output logic [1:0]  pc_reg_src,
  output logic        pc_write,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] retire_cnt,
  output logic [2:0]  fsm_state
);

  // Opcodes recognised by the decoder.
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [6:0]            opcode_q;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  illegal_q;
  logic                  bus_err_q;

  // Instruction class flags, all derived from the latched opcode.
  logic is_r, is_lw, is_sw, is_i, is_br, is_jalr, is_jal, is_lui, is_auipc;
  logic legal;

  assign is_r     = (opcode_q == OP_R);
  assign is_lw    = (opcode_q == OP_LW);
  assign is_sw    = (opcode_q == OP_SW);
  assign is_i     = (opcode_q == OP_I);
  assign is_br    = (opcode_q == OP_BR);
  assign is_jalr  = (opcode_q == OP_JALR);
  assign is_jal   = (opcode_q == OP_JAL);
  assign is_lui   = (opcode_q == OP_LUI);
  assign is_auipc = (opcode_q == OP_AUIPC);
  assign legal    = is_r | is_lw | is_sw | is_i | is_br | is_jalr |
                    is_jal | is_lui | is_auipc;

  // A timeout fires only when no ack arrives in the limit cycle; an ack in
  // that cycle wins.
  logic wait_expired;
  logic fetch_timeout;
  logic mem_timeout;

  assign wait_expired  = (wait_cnt == WAIT_LIMIT);
  assign fetch_timeout = (state == S_FETCH) && !imem_ack && wait_expired;
  assign mem_timeout   = (state == S_MEM)   && !dmem_ack && wait_expired;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)           state_next = S_DECODE;
        else if (fetch_timeout) state_next = S_TRAP;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_lw || is_sw)     state_next = S_MEM;
        else if (is_br)         state_next = S_FETCH;
        else                    state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)           state_next = is_sw ? S_FETCH : S_WB;
        else if (mem_timeout)   state_next = S_TRAP;
      end
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Opcode latch, wait counter and sticky trap flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= 7'h0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state == S_FETCH) && imem_ack) begin
        opcode_q <= opcode;
      end

      // Count restarts on every state change, so each request gets its own
      // budget. It advances only while a request is outstanding.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (((state == S_FETCH) && !imem_ack) ||
                   ((state == S_MEM)   && !dmem_ack)) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end

      if ((state == S_DECODE) && !legal) begin
        illegal_q <= 1'b1;
      end
      if (fetch_timeout || mem_timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output logic. Everything defaults low and is raised only in its phase.
  // IDLE and TRAP therefore drive no strobes. Because the outputs decode the
  // asynchronously reset state register, reset silences them immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    pc_to_reg  = 1'b0;
    pc_reg_src = 2'b00;
    pc_write   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXEC: begin
        alu_src  = is_lw | is_sw | is_i | is_jalr | is_lui | is_auipc;
        if (is_r)       alu_op = 2'b10;
        else if (is_i)  alu_op = 2'b11;
        else if (is_br) alu_op = 2'b01;
        else            alu_op = 2'b00;
        branch   = is_br;
        jump     = is_jal | is_jalr;
        jalr     = is_jalr;
        // Branches retire here; the compare result steers the PC mux.
        pc_write = is_br;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        alu_src  = 1'b1;
        alu_op   = 2'b00;
        // Stores retire on the ack cycle; loads still need writeback.
        pc_write = dmem_ack & is_sw;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = is_lw;
        pc_to_reg  = is_jal | is_jalr | is_lui | is_auipc;
        if (is_auipc)    pc_reg_src = 2'b01;
        else if (is_lui) pc_reg_src = 2'b10;
        else             pc_reg_src = 2'b00;
        jump       = is_jal | is_jalr;
        jalr       = is_jalr;
      end
      default: begin
      end
    endcase
  end

  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign fsm_state = state;

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 32'h0;
    end else if (pc_write) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. All control outputs are packed
// into one 18-bit vector, ctrl, and compared cycle by cycle against
// hand-built expected words. Inputs are driven 1 ns after the rising edge.
// Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, ir_load, dmem_req, dmem_we, alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg, reg_write, branch, jump, jalr, pc_to_reg;
  logic [1:0]  pc_reg_src;
  logic        pc_write, illegal, bus_err;
  logic [31:0] retire_cnt;
  logic [2:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Bit positions inside ctrl.
  localparam logic [17:0] B_IREQ  = 18'h20000;
  localparam logic [17:0] B_IRLD  = 18'h10000;
  localparam logic [17:0] B_DREQ  = 18'h08000;
  localparam logic [17:0] B_DWE   = 18'h04000;
  localparam logic [17:0] B_ASRC  = 18'h02000;
  localparam logic [17:0] B_OPBR  = 18'h00800;
  localparam logic [17:0] B_OPR   = 18'h01000;
  localparam logic [17:0] B_OPI   = 18'h01800;
  localparam logic [17:0] B_M2R   = 18'h00400;
  localparam logic [17:0] B_RW    = 18'h00200;
  localparam logic [17:0] B_BR    = 18'h00100;
  localparam logic [17:0] B_JMP   = 18'h00080;
  localparam logic [17:0] B_JALR  = 18'h00040;
  localparam logic [17:0] B_P2R   = 18'h00020;
  localparam logic [17:0] B_PSAUI = 18'h00008;
  localparam logic [17:0] B_PSLUI = 18'h00010;
  localparam logic [17:0] B_PCW   = 18'h00004;
  localparam logic [17:0] B_ILL   = 18'h00002;
  localparam logic [17:0] B_BERR  = 18'h00001;

  logic [17:0] ctrl;
  assign ctrl = {imem_req, ir_load, dmem_req, dmem_we, alu_src, alu_op,
                 mem_to_reg, reg_write, branch, jump, jalr, pc_to_reg,
                 pc_reg_src, pc_write, illegal, bus_err};

  multicycle_controller #(.WAIT_CNT_W(4), .WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .branch     (branch),
    .jump       (jump),
    .jalr       (jalr),
    .pc_to_reg  (pc_to_reg),
    .pc_reg_src (pc_reg_src),
    .pc_write   (pc_write),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .retire_cnt (retire_cnt),
    .fsm_state  (fsm_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // Drivers.
  // One controller cycle: inputs applied just after the rising edge, then
  // the caller observes outputs on the falling edge.
  task automatic drive(input logic ia, input logic da, input logic [6:0] op);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    opcode   = op;
    @(negedge clk);
  endtask

  // Reset pulse released on a falling edge. The next drive() call is the
  // first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    opcode   = 7'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scenarios.
  task automatic test_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    opcode   = OP_R;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctrl=%h expected=%h", ctrl, 18'h0);
    end
    checks++;
    if (retire_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_retire: retire_cnt=%0d expected=0", retire_cnt);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    opcode   = 7'h0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL idle_outputs: ctrl=%h expected=%h", ctrl, 18'h0);
    end
  endtask

  // FETCH (ack) -> DECODE -> EXEC -> WB -> FETCH. Opcode is only presented
  // in the ack cycle, so later cycles depend on the latched copy.
  task automatic test_alu_instr(input logic [6:0] op, input logic [17:0] exp_exec,
                                input logic [17:0] exp_wb, input string name);
    logic [17:0] exp [5];
    exp = '{B_IREQ | B_IRLD, 18'h0, exp_exec, exp_wb, B_IREQ};
    for (int i = 0; i < 5; i++) begin
      drive((i == 0), 1'b0, (i == 0) ? op : 7'h0);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: ctrl=%h expected=%h", name, i, ctrl, exp[i]);
      end
    end
  endtask

  // Load with a one-cycle late imem ack and a dmem ack 3 cycles late.
  task automatic test_lw();
    logic [17:0] exp [10];
    logic        ia  [10];
    logic        da  [10];
    exp = '{B_IREQ, B_IREQ | B_IRLD, 18'h0, B_ASRC,
            B_DREQ | B_ASRC, B_DREQ | B_ASRC, B_DREQ | B_ASRC, B_DREQ | B_ASRC,
            B_RW | B_PCW | B_M2R, B_IREQ};
    ia  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    da  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(ia[i], da[i], (i == 1) ? OP_LW : 7'h0);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL lw cycle %0d: ctrl=%h expected=%h", i, ctrl, exp[i]);
      end
    end
  endtask

  // Store with immediate dmem ack. Stray acks in DECODE/EXEC/FETCH must be
  // ignored.
  task automatic test_sw();
    logic [17:0] exp [5];
    logic        ia  [5];
    logic        da  [5];
    exp = '{B_IREQ | B_IRLD, 18'h0, B_ASRC, B_DREQ | B_DWE | B_ASRC | B_PCW, B_IREQ};
    ia  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    da  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(ia[i], da[i], (i == 0) ? OP_SW : 7'h0);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL sw cycle %0d: ctrl=%h expected=%h", i, ctrl, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [17:0] exp [4];
    exp = '{B_IREQ | B_IRLD, 18'h0, B_OPBR | B_BR | B_PCW, B_IREQ};
    for (int i = 0; i < 4; i++) begin
      drive((i == 0), 1'b0, (i == 0) ? OP_BR : 7'h0);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL branch cycle %0d: ctrl=%h expected=%h", i, ctrl, exp[i]);
      end
    end
  endtask

  // Reset asserted while a load waits in MEM.
  task automatic test_mid_reset();
    logic [17:0] exp [4];
    exp = '{B_IREQ | B_IRLD, 18'h0, B_ASRC, B_DREQ | B_ASRC};
    for (int i = 0; i < 4; i++) begin
      drive((i == 0), 1'b0, (i == 0) ? OP_LW : 7'h0);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d: ctrl=%h expected=%h", i, ctrl, exp[i]);
      end
    end
    #1;
    rst_n    = 1'b0;
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL mid_reset_async: ctrl=%h expected=%h", ctrl, 18'h0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL mid_reset_hold: ctrl=%h expected=%h", ctrl, 18'h0);
    end
    dmem_ack = 1'b0;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL mid_reset_idle: ctrl=%h expected=%h", ctrl, 18'h0);
    end
    drive(1'b0, 1'b0, 7'h0);
    checks++;
    if (ctrl !== B_IREQ) begin
      errors++;
      $display("FAIL mid_reset_fetch: ctrl=%h expected=%h", ctrl, B_IREQ);
    end
  endtask

  // Ten branches back to back, each fetch acked at once.
  task automatic test_back_to_back();
    logic [17:0] exp [3];
    logic [31:0] exp_cnt;
    exp = '{B_IREQ | B_IRLD, 18'h0, B_OPBR | B_BR | B_PCW};
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 3; i++) begin
        drive((i == 0), 1'b0, (i == 0) ? OP_BR : 7'h0);
        checks++;
        if (ctrl !== exp[i]) begin
          errors++;
          $display("FAIL b2b instr %0d cycle %0d: ctrl=%h expected=%h", n, i, ctrl, exp[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 7'h0);
    checks++;
    if (ctrl !== B_IREQ) begin
      errors++;
      $display("FAIL b2b_refetch: ctrl=%h expected=%h", ctrl, B_IREQ);
    end
`ifdef CTRL_RETIRE_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (retire_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL retire_cnt: retire_cnt=%0d expected=%0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] exp [8];
    exp = '{B_IREQ | B_IRLD, 18'h0, B_ILL, B_ILL, B_ILL, B_ILL, B_ILL, B_ILL};
    for (int i = 0; i < 8; i++) begin
      // From the DECODE cycle on, both acks are held high to show TRAP
      // ignores them.
      drive(1'b1, (i > 0), (i == 0) ? OP_BAD : OP_R);
      checks++;
      if (ctrl !== exp[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: ctrl=%h expected=%h", i, ctrl, exp[i]);
      end
    end
    do_reset();
    #1;
    checks++;
    if (ctrl !== 18'h0) begin
      errors++;
      $display("FAIL illegal_cleared: ctrl=%h expected=%h", ctrl, 18'h0);
    end
  endtask

  // imem ack arriving in the 16th un-acked cycle still wins.
  task automatic test_timeout_ack_wins();
    logic [17:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 15)       exp = B_IREQ;
      else if (i == 15) exp = B_IREQ | B_IRLD;
      else if (i == 16) exp = 18'h0;
      else if (i == 17) exp = B_OPR;
      else if (i == 18) exp = B_RW | B_PCW;
      else              exp = B_IREQ;
      drive((i == 15), 1'b0, (i == 15) ? OP_R : 7'h0);
      checks++;
      if (ctrl !== exp) begin
        errors++;
        $display("FAIL ack_wins cycle %0d: ctrl=%h expected=%h", i, ctrl, exp);
      end
    end
  endtask

  // No imem ack for 16 cycles -> bus_err and TRAP.
  task automatic test_fetch_timeout();
    logic [17:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp = (i < 16) ? B_IREQ : B_BERR;
      drive((i >= 17), (i >= 17), OP_R);
      checks++;
      if (ctrl !== exp) begin
        errors++;
        $display("FAIL fetch_timeout cycle %0d: ctrl=%h expected=%h", i, ctrl, exp);
      end
    end
  endtask

  // Load whose dmem ack never comes.
  task automatic test_mem_timeout();
    logic [17:0] exp;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (i == 0)      exp = B_IREQ | B_IRLD;
      else if (i == 1) exp = 18'h0;
      else if (i == 2) exp = B_ASRC;
      else if (i < 19) exp = B_DREQ | B_ASRC;
      else             exp = B_BERR;
      drive((i == 0), 1'b0, (i == 0) ? OP_LW : 7'h0);
      checks++;
      if (ctrl !== exp) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d: ctrl=%h expected=%h", i, ctrl, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_instr(OP_R,     B_OPR,                   B_RW | B_PCW,                           "rtype");
    test_alu_instr(OP_I,     B_ASRC | B_OPI,          B_RW | B_PCW,                           "itype");
    test_alu_instr(OP_JAL,   B_JMP,                   B_RW | B_PCW | B_P2R | B_JMP,           "jal");
    test_alu_instr(OP_JALR,  B_ASRC | B_JMP | B_JALR, B_RW | B_PCW | B_P2R | B_JMP | B_JALR,  "jalr");
    test_alu_instr(OP_LUI,   B_ASRC,                  B_RW | B_PCW | B_P2R | B_PSLUI,         "lui");
    test_alu_instr(OP_AUIPC, B_ASRC,                  B_RW | B_PCW | B_P2R | B_PSAUI,         "auipc");
    test_lw();
    test_sw();
    test_branch();
    test_mid_reset();
    test_back_to_back();
    test_illegal();
    test_timeout_ack_wins();
    test_fetch_timeout();
    test_mem_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
